// File: rtl/coin_credit_unit.sv
// coin_credit_unit: accumulates inserted coins into a credit register and
// resolves buy/cancel requests against a fixed price. The resulting outcome
// code and change amount are held under a valid/ack handshake until the
// downstream vending machine consumes them.
module coin_credit_unit #(
    parameter int unsigned CW         = 8,
    parameter int unsigned PRICE      = 15,
    parameter int unsigned MAX_CREDIT = 40
) (
    input  logic          c,
    input  logic          r,
    input  logic          coin_valid,
    input  logic [1:0]    coin_code,
    input  logic          buy,
    input  logic          cancel,
    input  logic          ack,
    output logic [CW-1:0] credit,
    output logic          coin_reject,
    output logic          out_valid,
    output logic [1:0]    out_code,
    output logic [CW-1:0] change
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SALDO_INSUF  = 2'b00,
        TROCO_REC    = 2'b01,
        DOCE_COMP    = 2'b10,
        DOCE_E_TROCO = 2'b11
    } outcome_t;

    localparam logic [CW-1:0] priceVal = CW'(PRICE);
    localparam logic [CW:0]   maxVal   = (CW+1)'(MAX_CREDIT);

    state_t        state, stateNext;
    logic [CW-1:0] creditNext;
    logic          coinRejectNext;
    logic          outValidNext;
    logic [1:0]    outCodeNext;
    logic [CW-1:0] changeNext;

    logic [CW:0]   coinVal;
    logic [CW:0]   coinSum;

    // Coin value decode and overflow-free sum one bit wider than the credit.
    always_comb begin
        coinVal = '0;
        case (coin_code)
            2'b00:   coinVal = (CW+1)'(1);
            2'b01:   coinVal = (CW+1)'(2);
            2'b10:   coinVal = (CW+1)'(5);
            default: coinVal = (CW+1)'(10);
        endcase
        coinSum = {1'b0, credit} + coinVal;
    end

    // Next-state and next-output logic; requests only act in COLLECT.
    always_comb begin
        stateNext      = state;
        creditNext     = credit;
        coinRejectNext = 1'b0;
        outValidNext   = out_valid;
        outCodeNext    = out_code;
        changeNext     = change;

        case (state)
            COLLECT: begin
                // A cancel with zero credit is a no-op, so it does not block
                // a simultaneous buy or coin.
                if (cancel && (credit != '0)) begin
                    stateNext      = HOLD;
                    outValidNext   = 1'b1;
                    outCodeNext    = TROCO_REC;
                    changeNext     = credit;
                    creditNext     = '0;
                    coinRejectNext = coin_valid;
                end else if (buy) begin
                    stateNext      = HOLD;
                    outValidNext   = 1'b1;
                    coinRejectNext = coin_valid;
                    if (credit < priceVal) begin
                        outCodeNext = SALDO_INSUF;
                        changeNext  = '0;
                    end else if (credit == priceVal) begin
                        outCodeNext = DOCE_COMP;
                        changeNext  = '0;
                        creditNext  = '0;
                    end else begin
                        outCodeNext = DOCE_E_TROCO;
                        changeNext  = credit - priceVal;
                        creditNext  = '0;
                    end
                end else if (coin_valid) begin
                    if (coinSum <= maxVal) begin
                        creditNext = coinSum[CW-1:0];
                    end else begin
                        coinRejectNext = 1'b1;
                    end
                end
            end
            HOLD: begin
                coinRejectNext = coin_valid;
                if (ack) begin
                    stateNext    = COLLECT;
                    outValidNext = 1'b0;
                    outCodeNext  = SALDO_INSUF;
                    changeNext   = '0;
                end
            end
            default: begin
                stateNext = COLLECT;
            end
        endcase
    end

    // State and registered outputs; synchronous reset overrides everything.
    always_ff @(posedge c) begin
        if (r) begin
            state       <= COLLECT;
            credit      <= '0;
            coin_reject <= 1'b0;
            out_valid   <= 1'b0;
            out_code    <= SALDO_INSUF;
            change      <= '0;
        end else begin
            state       <= stateNext;
            credit      <= creditNext;
            coin_reject <= coinRejectNext;
            out_valid   <= outValidNext;
            out_code    <= outCodeNext;
            change      <= changeNext;
        end
    end

endmodule

// File: tb/tb_coin_credit_unit.sv
// Directed testbench for coin_credit_unit with hand-computed expectations.
module tb_coin_credit_unit;

    logic       c = 1'b0;
    logic       r;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       buy;
    logic       cancel;
    logic       ack;
    logic [7:0] credit;
    logic       coin_reject;
    logic       out_valid;
    logic [1:0] out_code;
    logic [7:0] change;

    int passCount = 0;
    int failCount = 0;
    int total     = 0;

    coin_credit_unit #(.CW(8), .PRICE(15), .MAX_CREDIT(40)) dut (
        .c(c),
        .r(r),
        .coin_valid(coin_valid),
        .coin_code(coin_code),
        .buy(buy),
        .cancel(cancel),
        .ack(ack),
        .credit(credit),
        .coin_reject(coin_reject),
        .out_valid(out_valid),
        .out_code(out_code),
        .change(change)
    );

    // Free-running clock.
    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic insertCoin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic pulseBuy();
        buy = 1'b1;
        tick();
        buy = 1'b0;
    endtask

    task automatic pulseCancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic pulseAck();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // Directed stimulus sequence.
    initial begin
        r = 1'b1; coin_valid = 1'b0; coin_code = 2'b00;
        buy = 1'b0; cancel = 1'b0; ack = 1'b0;
        tick();
        tick();
        r = 1'b0;
        check("rst_credit", credit, 0);
        check("rst_valid", out_valid, 0);
        check("rst_code", out_code, 0);
        check("rst_change", change, 0);
        check("rst_reject", coin_reject, 0);

        // Exact price: 50c + 25c then buy.
        insertCoin(2'b11); check("t1_credit10", credit, 10);
        insertCoin(2'b10); check("t1_credit15", credit, 15);
        pulseBuy();
        check("t1_valid", out_valid, 1);
        check("t1_code", out_code, 2);
        check("t1_change", change, 0);
        check("t1_credit0", credit, 0);
        pulseAck();
        check("t1_ack_valid", out_valid, 0);
        check("t1_ack_change", change, 0);

        // Overpay: 20 units, change 5, held while ack low.
        insertCoin(2'b11); check("t2_credit10", credit, 10);
        insertCoin(2'b11); check("t2_credit20", credit, 20);
        pulseBuy();
        check("t2_valid", out_valid, 1);
        check("t2_code", out_code, 3);
        check("t2_change", change, 5);
        check("t2_credit0", credit, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_code", out_code, 3);
            check("t2_hold_change", change, 5);
        end
        pulseAck();
        check("t2_ack_valid", out_valid, 0);

        // Insufficient credit, then cancel refund.
        insertCoin(2'b01); check("t3_credit2", credit, 2);
        pulseBuy();
        check("t3_valid", out_valid, 1);
        check("t3_code", out_code, 0);
        check("t3_change", change, 0);
        check("t3_credit_kept", credit, 2);
        pulseAck();
        check("t3_ack_valid", out_valid, 0);
        pulseCancel();
        check("t3_cancel_valid", out_valid, 1);
        check("t3_cancel_code", out_code, 1);
        check("t3_cancel_change", change, 2);
        check("t3_cancel_credit", credit, 0);
        pulseAck();
        check("t3_ack2_valid", out_valid, 0);

        // Credit ceiling: 40 accepted, 41 rejected.
        insertCoin(2'b11); check("t4_credit10", credit, 10);
        insertCoin(2'b11); check("t4_credit20", credit, 20);
        insertCoin(2'b11); check("t4_credit30", credit, 30);
        insertCoin(2'b11); check("t4_credit40", credit, 40);
        check("t4_no_reject", coin_reject, 0);
        insertCoin(2'b00);
        check("t4_reject", coin_reject, 1);
        check("t4_credit_cap", credit, 40);
        tick();
        check("t4_reject_one_cycle", coin_reject, 0);
        pulseBuy();
        check("t4_code", out_code, 3);
        check("t4_change", change, 25);
        insertCoin(2'b10);
        check("t4_hold_reject", coin_reject, 1);
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_credit", credit, 0);
        pulseAck();
        check("t4_ack_valid", out_valid, 0);
        check("t4_ack_reject", coin_reject, 0);

        // buy + coin in same cycle; cancel with zero credit.
        insertCoin(2'b11);
        insertCoin(2'b10);
        check("t5_credit15", credit, 15);
        buy = 1'b1; coin_valid = 1'b1; coin_code = 2'b00;
        tick();
        buy = 1'b0; coin_valid = 1'b0;
        check("t5_valid", out_valid, 1);
        check("t5_code", out_code, 2);
        check("t5_reject", coin_reject, 1);
        check("t5_credit0", credit, 0);
        pulseAck();
        check("t5_ack_valid", out_valid, 0);
        pulseCancel();
        check("t5_cancel0_valid", out_valid, 0);
        check("t5_cancel0_credit", credit, 0);

        // Reset during HOLD.
        insertCoin(2'b11);
        insertCoin(2'b11);
        pulseBuy();
        check("t6_code", out_code, 3);
        r = 1'b1;
        tick();
        r = 1'b0;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_code", out_code, 0);
        check("t6_rst_change", change, 0);
        check("t6_rst_credit", credit, 0);
        insertCoin(2'b10);
        check("t6_new_credit", credit, 5);
        check("t6_new_reject", coin_reject, 0);

        $display("%0d/%0d checks passed", passCount, total);
        $finish;
    end

endmodule
